// File: rtl/dpu_fram_pkg.sv
// Shared definitions for the frame-memory accumulate unit.
// Contains the controller state encoding and the position of the attribute carry flag.
package dpu_fram_pkg;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // The carry of an accumulate is recorded in the top attribute bit.
  function automatic int carry_idx(input int wa);
    return wa - 1;
  endfunction

endpackage

// File: rtl/dpu_fram_acc_if.sv
// Processor-bus side of the frame-memory accumulate unit.
// The master drives requests and the slave returns read data and busy.
interface dpu_fram_acc_if #(
  parameter int W     = 32,
  parameter int WA    = 4,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
);
  logic [AW-1:0] dp_addr;
  logic          dp_wr;
  logic          dp_acc;
  logic [W-1:0]  dp_data;
  logic [WA-1:0] dp_attr_i;
  logic          dp_oe;
  logic          dp_clear;
  logic [W-1:0]  dp_value;
  logic [WA-1:0] dp_attr_o;
  logic          dp_busy;

  modport master (
    output dp_addr, dp_wr, dp_acc, dp_data, dp_attr_i, dp_oe, dp_clear,
    input  dp_value, dp_attr_o, dp_busy
  );

  modport slave (
    input  dp_addr, dp_wr, dp_acc, dp_data, dp_attr_i, dp_oe, dp_clear,
    output dp_value, dp_attr_o, dp_busy
  );
endinterface

// File: rtl/dpu_fram_ram.sv
// Cell storage: DEPTH x CW register bank with one write port and one async read port.
// Not reset; the controller's clear sweep initialises it.
module dpu_fram_ram #(
  parameter int CW    = 36,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [CW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [CW-1:0] rdata
);

  logic [CW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dpu_fram_acc.sv
// Frame-memory unit with overwrite/accumulate writes, one-stage write pipeline with
// read forwarding, registered OR-bus-safe read port and a clear sweep after reset.
module dpu_fram_acc
  import dpu_fram_pkg::*;
#(
  parameter int W     = 32,
  parameter int WA    = 4,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic dp_clk,
  input  logic dp_rst_n,
  dpu_fram_acc_if.slave bus
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic [WA-1:0] attr;
    logic          acc;
    logic          valid;
  } stg_t;

  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  stg_t             stg_p1_q, stg_p1_d;
  logic [W+WA-1:0]  old_p1_q, old_p1_d;
  logic [W-1:0]     value_q, value_d;
  logic [WA-1:0]    attr_q, attr_d;

  logic [W:0]       sum_p2;
  logic [W+WA-1:0]  cmt_p2;
  logic [W+WA-1:0]  rd_cell;
  logic [W+WA-1:0]  fwd_cell;
  logic             accept;
  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [W+WA-1:0]  ram_wdata;

  // ---- stage 2: commit the captured request using the old value fetched at capture
  always_comb begin
    sum_p2 = {1'b0, old_p1_q[W+WA-1:WA]} + {1'b0, stg_p1_q.data};
    cmt_p2 = {stg_p1_q.data, stg_p1_q.attr};
    if (stg_p1_q.acc)
      cmt_p2 = {sum_p2[W-1:0], stg_p1_q.attr | (WA'(sum_p2[W]) << carry_idx(WA))};
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = stg_p1_q.addr;
    ram_wdata = cmt_p2;
    if (dp_rst_n) begin
      if (state_q == ST_CLEAR) begin
        ram_we    = 1'b1;
        ram_waddr = ptr_q;
        ram_wdata = '0;
      end else begin
        ram_we = stg_p1_q.valid;
      end
    end
  end

  dpu_fram_ram #(.CW(W + WA), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (dp_clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (bus.dp_addr),
    .rdata (rd_cell)
  );

  // ---- stage 1: capture request; its old value is the cell with this cycle's commit forwarded
  always_comb begin
    accept   = (state_q == ST_READY) && !bus.dp_clear;
    fwd_cell = (stg_p1_q.valid && (stg_p1_q.addr == bus.dp_addr)) ? cmt_p2 : rd_cell;

    stg_p1_d.addr  = bus.dp_addr;
    stg_p1_d.data  = bus.dp_data;
    stg_p1_d.attr  = bus.dp_attr_i;
    stg_p1_d.acc   = bus.dp_acc;
    stg_p1_d.valid = accept && bus.dp_wr;
    old_p1_d       = fwd_cell;

    value_d = '0;
    attr_d  = '0;
    if (accept && bus.dp_oe) begin
      value_d = fwd_cell[W+WA-1:WA];
      attr_d  = fwd_cell[WA-1:0];
    end

    state_d = state_q;
    ptr_d   = ptr_q;
    if (bus.dp_clear) begin
      state_d = ST_CLEAR;
      ptr_d   = '0;
    end else if (state_q == ST_CLEAR) begin
      ptr_d = AW'(ptr_q + 1'b1);
      if (ptr_q == AW'(DEPTH - 1)) begin
        state_d = ST_READY;
        ptr_d   = '0;
      end
    end
  end

  always_ff @(posedge dp_clk) begin
    stg_p1_q <= stg_p1_d;
    old_p1_q <= old_p1_d;
    if (!dp_rst_n) begin
      state_q        <= ST_CLEAR;
      ptr_q          <= '0;
      stg_p1_q.valid <= 1'b0;
      value_q        <= '0;
      attr_q         <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      value_q <= value_d;
      attr_q  <= attr_d;
    end
  end

  assign bus.dp_value  = value_q;
  assign bus.dp_attr_o = attr_q;
  assign bus.dp_busy   = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_dpu_fram_acc.sv
// Bench for dpu_fram_acc: directed scenarios plus random traffic checked against
// an instant-update memory model with a busy countdown.
module tb_dpu_fram_acc;

  localparam int W     = 32;
  localparam int WA    = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic dp_clk = 1'b0;
  logic dp_rst_n = 1'b0;
  always #5 dp_clk = ~dp_clk;

  dpu_fram_acc_if #(.W(W), .WA(WA), .DEPTH(DEPTH), .AW(AW)) bus ();

  dpu_fram_acc #(.W(W), .WA(WA), .DEPTH(DEPTH), .AW(AW)) dut (
    .dp_clk   (dp_clk),
    .dp_rst_n (dp_rst_n),
    .bus      (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0]  mv [DEPTH];
  logic [WA-1:0] ma [DEPTH];
  int            busy_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) begin
      mv[i] = '0;
      ma[i] = '0;
    end
  endtask

  // One bus cycle: drive, update the model, clock, then compare all outputs.
  task automatic step(input logic rst_n, input logic clr, input logic wr, input logic acc,
                      input logic oe, input logic [AW-1:0] addr, input logic [W-1:0] data,
                      input logic [WA-1:0] attr);
    logic [W-1:0]  exp_v;
    logic [WA-1:0] exp_a;
    logic [W:0]    s;
    logic          ok;
    dp_rst_n         = rst_n;
    bus.dp_clear     = clr;
    bus.dp_wr        = wr;
    bus.dp_acc       = acc;
    bus.dp_oe        = oe;
    bus.dp_addr      = addr;
    bus.dp_data      = data;
    bus.dp_attr_i    = attr;
    exp_v = '0;
    exp_a = '0;
    if (!rst_n) begin
      model_zero();
      busy_cnt = DEPTH;
    end else begin
      ok = (busy_cnt == 0) && !clr;
      if (ok && oe) begin
        exp_v = mv[addr];
        exp_a = ma[addr];
      end
      if (ok && wr) begin
        if (acc) begin
          s = {1'b0, mv[addr]} + {1'b0, data};
          mv[addr] = s[W-1:0];
          ma[addr] = attr | {s[W], {(WA-1){1'b0}}};
        end else begin
          mv[addr] = data;
          ma[addr] = attr;
        end
      end
      if (clr) begin
        busy_cnt = DEPTH;
        model_zero();
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
    end
    @(posedge dp_clk);
    #1;
    check("busy",  {63'd0, bus.dp_busy}, {63'd0, busy_cnt > 0});
    check("value", {32'd0, bus.dp_value}, {32'd0, exp_v});
    check("attr",  {60'd0, bus.dp_attr_o}, {60'd0, exp_a});
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic wr_cell(input logic [AW-1:0] a, input logic [W-1:0] d,
                         input logic [WA-1:0] at, input logic acc);
    step(1'b1, 1'b0, 1'b1, acc, 1'b0, a, d, at);
  endtask

  task automatic rd_cell(input logic [AW-1:0] a);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, a, '0, '0);
  endtask

  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    check("rst_busy", {63'd0, bus.dp_busy}, 64'd1);
    for (int i = 0; i < DEPTH; i++) idle();
    check("sweep_done", {63'd0, bus.dp_busy}, 64'd0);
    for (int a = 0; a < DEPTH; a++) rd_cell(AW'(a));

    wr_cell(4'd3, 32'hA3, 4'h2, 1'b0);
    rd_cell(4'd3);
    check("a3_value", {32'd0, bus.dp_value}, 64'hA3);
    check("a3_attr",  {60'd0, bus.dp_attr_o}, 64'h2);
    idle();
    check("idle_zero", {32'd0, bus.dp_value}, 64'd0);

    wr_cell(4'd5, 32'd10, 4'h0, 1'b0);
    wr_cell(4'd5, 32'd7,  4'h0, 1'b1);
    wr_cell(4'd5, 32'd8,  4'h0, 1'b1);
    rd_cell(4'd5);
    check("acc25", {32'd0, bus.dp_value}, 64'd25);
    check("acc25_carry", {63'd0, bus.dp_attr_o[WA-1]}, 64'd0);

    wr_cell(4'd7, 32'hFFFF_FFFF, 4'h0, 1'b0);
    wr_cell(4'd7, 32'd2, 4'h0, 1'b1);
    rd_cell(4'd7);
    check("wrap_value", {32'd0, bus.dp_value}, 64'd1);
    check("wrap_attr",  {60'd0, bus.dp_attr_o}, 64'h8);

    wr_cell(4'd2, 32'h11, 4'h1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 32'h22, 4'h1);
    check("rbw_old", {32'd0, bus.dp_value}, 64'h11);
    rd_cell(4'd2);
    check("rbw_new", {32'd0, bus.dp_value}, 64'h22);

    wr_cell(4'd9, 32'h55, 4'h3, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 5; i++) idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < DEPTH; i++) idle();
    check("resweep_done", {63'd0, bus.dp_busy}, 64'd0);
    rd_cell(4'd9);
    rd_cell(4'd7);

    for (int n = 0; n < 3000; n++) begin
      logic rst_n, clr;
      logic [AW-1:0] a;
      rst_n = ($urandom_range(0, 499) != 0);
      clr   = ($urandom_range(0, 249) == 0);
      a     = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3));
      step(rst_n, clr, 1'($urandom), 1'($urandom), 1'($urandom), a,
           ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | W'($urandom_range(0, 15)) : W'($urandom),
           WA'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
